// File: rtl/can_crc_seq.sv
// ---------------------------------------------------------------------------
// can_crc_seq
// CAN CRC-15 sequencer. The block accumulates the CRC over the destuffed
// frame bits from SOF through the end of the data field. In TX mode it then
// serializes the 15-bit CRC MSB first. In RX mode it compares the 15 received
// CRC bits against the computed value. A one-cycle done pulse reports the
// result on crc_ok.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset; overrides every other input
//   start         one-cycle frame start; accepted only in IDLE
//   mode          1 = TX (generate/serialize), 0 = RX (check); sampled with start
//   cov_len[7:0]  number of covered bits; sampled with start
//   bit_in        destuffed frame bit, qualified by bit_valid
//   bit_valid     bit strobe; also advances the TX CRC bit slot
//   abort         level; returns any busy state to IDLE without a done pulse
//   busy          high in every state except IDLE
//   crc_out_bit   TX CRC bit, MSB first (meaningful while crc_out_valid)
//   crc_out_valid high only while serializing the TX CRC
//   crc_value     CRC over the covered bits; held until the next accepted start
//   done          one-cycle completion pulse
//   crc_ok        pass/fail result, valid while done is high
// ---------------------------------------------------------------------------
module can_crc_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [7:0]  cov_len,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        abort,
    output logic        busy,
    output logic        crc_out_bit,
    output logic        crc_out_valid,
    output logic [14:0] crc_value,
    output logic        done,
    output logic        crc_ok
);

    localparam logic [14:0] CRC_POLY = 15'h4599;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_TX_CRC,
        S_RX_CRC,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [14:0] crc_q;        // running CRC during ACCUM
    logic [14:0] shift_q;      // CRC being serialized or compared
    logic [7:0]  cnt_q;        // covered-bit count, then CRC-bit count
    logic        err_q;        // sticky RX compare error
    logic        mode_q;
    logic [7:0]  len_q;
    logic [14:0] crc_value_q;

    logic [14:0] crc_d;        // CRC after absorbing bit_in
    logic [7:0]  cnt_d;        // counter plus one

    always_comb begin
        crc_d = {crc_q[13:0], 1'b0};
        if (crc_q[14] ^ bit_in) begin
            crc_d = {crc_q[13:0], 1'b0} ^ CRC_POLY;
        end
        cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            crc_q       <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mode_q      <= 1'b0;
            len_q       <= '0;
            crc_value_q <= '0;
        end else if (state_q != S_IDLE && abort) begin
            // Frame dropped; crc_value deliberately keeps its prior contents.
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // abort in IDLE swallows a coincident start
                    if (start && !abort) begin
                        crc_q  <= '0;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                        mode_q <= mode;
                        len_q  <= cov_len;
                        if (cov_len == 8'd0) begin
                            // Empty coverage: the CRC of nothing is zero.
                            crc_value_q <= '0;
                            shift_q     <= '0;
                            state_q     <= mode ? S_TX_CRC : S_RX_CRC;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                end

                S_ACCUM: begin
                    if (bit_valid) begin
                        crc_q <= crc_d;
                        if (cnt_d == len_q) begin
                            crc_value_q <= crc_d;
                            shift_q     <= crc_d;
                            cnt_q       <= '0;
                            state_q     <= mode_q ? S_TX_CRC : S_RX_CRC;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end

                S_TX_CRC, S_RX_CRC: begin
                    if (bit_valid) begin
                        if (state_q == S_RX_CRC && bit_in != shift_q[14]) begin
                            err_q <= 1'b1;
                        end
                        shift_q <= {shift_q[13:0], 1'b0};
                        if (cnt_q == 8'd14) begin
                            cnt_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the state register. They are forced low while rst is
    // held, so reset wins even before the first clock edge.
    assign busy          = !rst && (state_q != S_IDLE);
    assign crc_out_valid = !rst && (state_q == S_TX_CRC);
    assign crc_out_bit   = !rst && (state_q == S_TX_CRC) && shift_q[14];
    assign done          = !rst && (state_q == S_DONE);
    assign crc_ok        = !rst && (state_q == S_DONE) && (mode_q || !err_q);
    assign crc_value     = rst ? 15'h0000 : crc_value_q;

endmodule
